sdram_bus_bridge: RTL and testbench

- Sits directly upstream of the SDRAM controller and adapts the 32-bit CPU data bus to the controller's 16-bit single-access host interface.
- Each 32-bit access becomes up to two sequential halfword accesses (low, then high), and halves with no enabled bytes are skipped.
- It holds off traffic until SDRAM configuration completes, and it quiesces after reset because the controller itself has no reset.

---
 rtl/sdram_pkg.sv | 22 ++
 rtl/sdram_bus_bridge.sv | 226 ++++++++++++++++++++++
 tb/tb_sdram_bus_bridge.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sdram_pkg                                                 |
// | Desc     : Shared state type and constants for sdram_bus_bridge.     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package sdram_pkg;

  typedef enum logic [2:0] {
    QUIESCE  = 3'd0,
    WAIT_CFG = 3'd1,
    IDLE     = 3'd2,
    LO       = 3'd3,
    HI       = 3'd4,
    ACK      = 3'd5
  } state_t;

  localparam logic [31:0] c_HALF_OFFSET        = 32'd2;
  localparam int          c_QUIESCE_CYCLES_DEF = 16;

endpackage
`default_nettype wire

// File: rtl/sdram_bus_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sdram_bus_bridge                                          |
// | Desc     : 32-bit CPU bus to 16-bit SDRAM controller host bridge.    |
// |            Define SDRAM_BRIDGE_POSTED_WRITE_EN for posted writes.    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module sdram_bus_bridge
  import sdram_pkg::*;
#(
  parameter int QUIESCE_CYCLES = c_QUIESCE_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  input  logic [3:0]  b_bytesel,
  input  logic        b_wr_en,
  input  logic        b_access,
  output logic        b_ack,
  output logic [31:0] b_rdata,
  output logic [31:0] h_addr,
  output logic [15:0] h_wdata,
  input  logic [15:0] h_rdata,
  output logic        h_wr_en,
  output logic [1:0]  h_bytesel,
  input  logic        h_compl,
  input  logic        h_config_done
);

  localparam int              c_QW    = (QUIESCE_CYCLES > 1) ? $clog2(QUIESCE_CYCLES) : 1;
  localparam logic [c_QW-1:0] c_QLAST = c_QW'(QUIESCE_CYCLES - 1);

  state_t          r_state, w_next;
  logic [c_QW-1:0] r_qcnt, w_qcnt;

  logic [29:0] r_base;
  logic [15:0] r_wdata_hi;
  logic [1:0]  r_bs_hi;
  logic [31:0] r_cap, w_cap;
  logic        w_latch;

  logic        r_b_ack, w_b_ack;
  logic [31:0] r_b_rdata, w_b_rdata;
  logic [31:0] r_h_addr, w_h_addr;
  logic [15:0] r_h_wdata, w_h_wdata;
  logic        r_h_wr_en, w_h_wr_en;
  logic [1:0]  r_h_bytesel, w_h_bytesel;

  logic [31:0] w_acc_base;
  logic        w_post_acc;
  logic        w_post_run;
  logic        w_unused;

  assign w_acc_base = {b_addr[31:2], 2'b00};
  assign w_unused   = &{1'b0, b_addr[1:0]};

`ifdef SDRAM_BRIDGE_POSTED_WRITE_EN
  logic r_posted;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_posted <= 1'b0;
    end else if (w_latch) begin
      r_posted <= b_wr_en;
    end
  end

  assign w_post_acc = b_wr_en;
  assign w_post_run = r_posted;
`else
  assign w_post_acc = 1'b0;
  assign w_post_run = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= QUIESCE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_qcnt      = r_qcnt;
    w_latch     = 1'b0;
    w_cap       = r_cap;
    w_b_ack     = 1'b0;
    w_b_rdata   = r_b_rdata;
    w_h_addr    = r_h_addr;
    w_h_wdata   = r_h_wdata;
    w_h_wr_en   = r_h_wr_en;
    w_h_bytesel = 2'b00;

    case (r_state)
      QUIESCE: begin
        if (r_qcnt == c_QLAST) begin
          w_next = WAIT_CFG;
        end else begin
          w_qcnt = r_qcnt + c_QW'(1);
        end
      end

      WAIT_CFG: begin
        if (h_config_done) begin
          w_next = IDLE;
        end
      end

      IDLE: begin
        if (b_access) begin
          w_latch   = 1'b1;
          w_cap     = '0;
          w_h_wr_en = b_wr_en;
          if (|b_bytesel[1:0]) begin
            w_next      = LO;
            w_h_bytesel = b_bytesel[1:0];
            w_h_wdata   = b_wdata[15:0];
            w_h_addr    = w_acc_base;
          end else if (|b_bytesel[3:2]) begin
            w_next      = HI;
            w_h_bytesel = b_bytesel[3:2];
            w_h_wdata   = b_wdata[31:16];
            w_h_addr    = w_acc_base + c_HALF_OFFSET;
          end else begin
            w_next = ACK;
          end
          if (w_post_acc) begin
            w_b_ack   = 1'b1;
            w_b_rdata = '0;
          end
        end
      end

      LO: begin
        if (h_compl) begin
          w_cap[15:0] = h_rdata;
          if (|r_bs_hi) begin
            w_next      = HI;
            w_h_bytesel = r_bs_hi;
            w_h_wdata   = r_wdata_hi;
            w_h_addr    = {r_base, 2'b00} + c_HALF_OFFSET;
          end else if (w_post_run) begin
            w_next = IDLE;
          end else begin
            w_next    = ACK;
            w_b_ack   = 1'b1;
            w_b_rdata = {r_cap[31:16], h_rdata};
          end
        end else begin
          w_h_bytesel = r_h_bytesel;
        end
      end

      HI: begin
        if (h_compl) begin
          w_cap[31:16] = h_rdata;
          if (w_post_run) begin
            w_next = IDLE;
          end else begin
            w_next    = ACK;
            w_b_ack   = 1'b1;
            w_b_rdata = {h_rdata, r_cap[15:0]};
          end
        end else begin
          w_h_bytesel = r_h_bytesel;
        end
      end

      ACK: begin
        // Arriving straight from IDLE (no halves issued) the pulse has not
        // been raised yet, so ACK lingers one cycle to emit it.
        if (r_b_ack) begin
          w_next = IDLE;
        end else begin
          w_b_ack   = 1'b1;
          w_b_rdata = r_cap;
        end
      end

      default: begin
        w_next = QUIESCE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_qcnt      <= '0;
      r_base      <= '0;
      r_wdata_hi  <= '0;
      r_bs_hi     <= '0;
      r_cap       <= '0;
      r_b_ack     <= 1'b0;
      r_b_rdata   <= '0;
      r_h_addr    <= '0;
      r_h_wdata   <= '0;
      r_h_wr_en   <= 1'b0;
      r_h_bytesel <= 2'b00;
    end else begin
      r_qcnt      <= w_qcnt;
      r_cap       <= w_cap;
      r_b_ack     <= w_b_ack;
      r_b_rdata   <= w_b_rdata;
      r_h_addr    <= w_h_addr;
      r_h_wdata   <= w_h_wdata;
      r_h_wr_en   <= w_h_wr_en;
      r_h_bytesel <= w_h_bytesel;
      if (w_latch) begin
        r_base     <= b_addr[31:2];
        r_wdata_hi <= b_wdata[31:16];
        r_bs_hi    <= b_bytesel[3:2];
      end
    end
  end

  assign b_ack     = r_b_ack;
  assign b_rdata   = r_b_rdata;
  assign h_addr    = r_h_addr;
  assign h_wdata   = r_h_wdata;
  assign h_wr_en   = r_h_wr_en;
  assign h_bytesel = r_h_bytesel;

endmodule
`default_nettype wire

// File: tb/tb_sdram_bus_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_sdram_bus_bridge                                       |
// | Desc     : Directed self-checking bench for sdram_bus_bridge.        |
// |            Honours SDRAM_BRIDGE_POSTED_WRITE_EN when defined.        |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_sdram_bus_bridge;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] b_addr;
  logic [31:0] b_wdata;
  logic [3:0]  b_bytesel;
  logic        b_wr_en;
  logic        b_access;
  logic        b_ack;
  logic [31:0] b_rdata;
  logic [31:0] h_addr;
  logic [15:0] h_wdata;
  logic [15:0] h_rdata;
  logic        h_wr_en;
  logic [1:0]  h_bytesel;
  logic        h_compl;
  logic        h_config_done;

  int   n_total  = 0;
  int   n_pass   = 0;
  int   n_req    = 0;
  int   n_ack    = 0;
  logic prev_req = 1'b0;

  always #5 clk = ~clk;

  sdram_bus_bridge dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .b_addr        (b_addr),
    .b_wdata       (b_wdata),
    .b_bytesel     (b_bytesel),
    .b_wr_en       (b_wr_en),
    .b_access      (b_access),
    .b_ack         (b_ack),
    .b_rdata       (b_rdata),
    .h_addr        (h_addr),
    .h_wdata       (h_wdata),
    .h_rdata       (h_rdata),
    .h_wr_en       (h_wr_en),
    .h_bytesel     (h_bytesel),
    .h_compl       (h_compl),
    .h_config_done (h_config_done)
  );

  // Counts new controller requests and ack pulses, sampled just after each edge.
  always @(posedge clk) begin
    #1;
    if (((|h_bytesel) === 1'b1) && !prev_req) n_req = n_req + 1;
    prev_req = ((|h_bytesel) === 1'b1);
    if (b_ack === 1'b1) n_ack = n_ack + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total = n_total + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic compl(input logic [15:0] d);
    h_compl = 1'b1;
    h_rdata = d;
    @(negedge clk);
    h_compl = 1'b0;
    h_rdata = 16'h0000;
  endtask

  task automatic wait_req(input int lim, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if ((|h_bytesel) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] bs, input logic wr);
    b_addr    = a;
    b_wdata   = d;
    b_bytesel = bs;
    b_wr_en   = wr;
    b_access  = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    int   base_req;
    int   base_ack;

    reset_n = 1'b0; b_access = 1'b0; b_addr = '0; b_wdata = '0; b_bytesel = '0;
    b_wr_en = 1'b0; h_rdata = '0; h_compl = 1'b0; h_config_done = 1'b0;
    req(32'h0000_0100, 32'h0, 4'hF, 1'b0);
    cyc(2);
    chk("rst b_ack",     32'(b_ack),     32'h0);
    chk("rst b_rdata",   b_rdata,        32'h0);
    chk("rst h_bytesel", 32'(h_bytesel), 32'h0);
    chk("rst h_addr",    h_addr,         32'h0);
    chk("rst h_wdata",   32'(h_wdata),   32'h0);
    chk("rst h_wr_en",   32'(h_wr_en),   32'h0);

    // Quiesce and config gating with b_access held and a stray completion.
    reset_n  = 1'b1;
    base_req = n_req;
    base_ack = n_ack;
    for (int i = 1; i <= 40; i++) begin
      h_compl = (i == 20);
      @(negedge clk);
    end
    h_compl = 1'b0;
    chk("gate no req", 32'(n_req - base_req), 32'h0);
    chk("gate no ack", 32'(n_ack - base_ack), 32'h0);
    h_config_done = 1'b1;

    // Full read.
    wait_req(10, ok);
    chk("rd lo issued",  32'(ok),        32'h1);
    chk("rd lo addr",    h_addr,         32'h0000_0100);
    chk("rd lo bytesel", 32'(h_bytesel), 32'h3);
    chk("rd wr_en",      32'(h_wr_en),   32'h0);
    cyc(2);
    chk("rd lo held",    32'(h_bytesel), 32'h3);
    compl(16'hBEEF);
    chk("rd hi addr",    h_addr,         32'h0000_0102);
    chk("rd hi bytesel", 32'(h_bytesel), 32'h3);
    chk("rd no early ack", 32'(b_ack),   32'h0);
    cyc(3);
    compl(16'hDEAD);
    chk("rd ack",        32'(b_ack),     32'h1);
    chk("rd data",       b_rdata,        32'hDEAD_BEEF);
    chk("rd req dropped", 32'(h_bytesel), 32'h0);
    b_access = 1'b0;
    cyc(1);
    chk("rd ack one cycle", 32'(b_ack),  32'h0);
    chk("rd data held",  b_rdata,        32'hDEAD_BEEF);

    // Upper-half write: one controller access only.
    base_req = n_req;
    req(32'h0000_0200, 32'h1234_5678, 4'b1100, 1'b1);
    cyc(1);
    chk("wr hi bytesel", 32'(h_bytesel), 32'h3);
    chk("wr hi addr",    h_addr,         32'h0000_0202);
    chk("wr hi wdata",   32'(h_wdata),   32'h1234);
    chk("wr wr_en",      32'(h_wr_en),   32'h1);
`ifdef SDRAM_BRIDGE_POSTED_WRITE_EN
    chk("wr posted ack", 32'(b_ack),     32'h1);
    b_access = 1'b0;
`else
    chk("wr ack waits",  32'(b_ack),     32'h0);
`endif
    cyc(1);
    compl(16'h7777);
`ifdef SDRAM_BRIDGE_POSTED_WRITE_EN
    chk("wr posted no 2nd ack", 32'(b_ack), 32'h0);
`else
    chk("wr ack",        32'(b_ack),     32'h1);
    b_access = 1'b0;
`endif
    chk("wr req dropped", 32'(h_bytesel), 32'h0);
    cyc(3);
    chk("wr single access", 32'(n_req - base_req), 32'h1);

    // Zero byte enables: ack two cycles after acceptance, no traffic.
    base_req = n_req;
    req(32'h0000_0300, 32'h0, 4'h0, 1'b0);
    cyc(1);
    chk("zero ack not yet", 32'(b_ack),  32'h0);
    cyc(1);
    chk("zero ack",      32'(b_ack),     32'h1);
    chk("zero rdata",    b_rdata,        32'h0);
    b_access = 1'b0;
    cyc(2);
    chk("zero no traffic", 32'(n_req - base_req), 32'h0);
    chk("zero ack single", 32'(b_ack),   32'h0);

    // Reset while the low half is outstanding.
    req(32'h0000_0400, 32'h0, 4'b0011, 1'b0);
    cyc(1);
    chk("mid lo issued", 32'(h_bytesel), 32'h3);
    reset_n  = 1'b0;
    b_access = 1'b0;
    cyc(1);
    reset_n = 1'b1;
    chk("mid rst bytesel", 32'(h_bytesel), 32'h0);
    chk("mid rst ack",   32'(b_ack),     32'h0);
    chk("mid rst addr",  h_addr,         32'h0);
    base_ack = n_ack;
    cyc(2);
    compl(16'h5555);
    req(32'h0000_0400, 32'h0, 4'b0011, 1'b0);
    wait_req(40, ok);
    chk("mid re-issued", 32'(ok),        32'h1);
    chk("mid no stray ack", 32'(n_ack - base_ack), 32'h0);
    chk("mid addr",      h_addr,         32'h0000_0400);
    compl(16'hCAFE);
    chk("mid ack",       32'(b_ack),     32'h1);
    chk("mid rdata",     b_rdata,        32'h0000_CAFE);
    b_access = 1'b0;
    cyc(1);

    // Full write followed immediately by a read.
    req(32'h0000_0600, 32'hA5A5_5A5A, 4'hF, 1'b1);
    cyc(1);
    chk("wr2 lo addr",   h_addr,         32'h0000_0600);
    chk("wr2 lo data",   32'(h_wdata),   32'h5A5A);
`ifdef SDRAM_BRIDGE_POSTED_WRITE_EN
    chk("post ack",      32'(b_ack),     32'h1);
    req(32'h0000_0700, 32'h0, 4'hF, 1'b0);
    cyc(2);
    chk("post rd waits", h_addr,         32'h0000_0600);
    compl(16'h0000);
    chk("post hi addr",  h_addr,         32'h0000_0602);
    chk("post hi data",  32'(h_wdata),   32'hA5A5);
    cyc(1);
    compl(16'h0000);
    chk("post done",     32'(h_bytesel), 32'h0);
    chk("post no ack",   32'(b_ack),     32'h0);
    cyc(1);
`else
    chk("wr2 no early ack", 32'(b_ack),  32'h0);
    cyc(2);
    compl(16'h0000);
    chk("wr2 hi addr",   h_addr,         32'h0000_0602);
    chk("wr2 hi data",   32'(h_wdata),   32'hA5A5);
    chk("wr2 hi no ack", 32'(b_ack),     32'h0);
    cyc(1);
    compl(16'h0000);
    chk("wr2 ack",       32'(b_ack),     32'h1);
    req(32'h0000_0700, 32'h0, 4'hF, 1'b0);
    cyc(1);
    chk("rd2 waits",     32'(h_bytesel), 32'h0);
    cyc(1);
`endif
    chk("rd2 lo addr",   h_addr,         32'h0000_0700);
    chk("rd2 wr_en",     32'(h_wr_en),   32'h0);
    chk("rd2 bytesel",   32'(h_bytesel), 32'h3);
    compl(16'h1111);
    chk("rd2 hi addr",   h_addr,         32'h0000_0702);
    compl(16'h2222);
    chk("rd2 ack",       32'(b_ack),     32'h1);
    chk("rd2 data",      b_rdata,        32'h2222_1111);
    b_access = 1'b0;
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
